// File: rtl/uart_defs.sv
// Shared definitions for the buffered UART echo block: TX FSM states,
// default baud divider and the saturating counter helper.
package uart_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLK_PER_HALF_BIT = 5208;

  // Increment that sticks at max_value instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value == max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count and registered read data.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic [FIFO_AW:0] count,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         dout_q;
  logic               do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign dout    = dout_q;

  // Next pointer and occupancy values; pointers wrap naturally modulo depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and read-data registers; reset discards stored bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_pop) dout_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, finds the start-bit falling edge,
// samples each bit near its centre and pulses rx_ready after the stop bit.
module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_ready,
  output logic       ferr
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_PRELOAD = CW'(CLK_PER_HALF_BIT);

  logic [2:0]    sync_q;
  logic          active_q;
  logic [3:0]    bits_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    shift_q, rdata_q;
  logic          ready_q, ferr_q;

  assign rdata    = rdata_q;
  assign rx_ready = ready_q;
  assign ferr     = ferr_q;

  // Frame reception: bit 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q   <= '1;
      active_q <= 1'b0;
      bits_q   <= 4'd0;
      cnt_q    <= '0;
      shift_q  <= 8'h00;
      rdata_q  <= 8'h00;
      ready_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rxd};
      ready_q <= 1'b0;
      if (!active_q) begin
        if (sync_q[2] && !sync_q[1]) begin
          active_q <= 1'b1;
          bits_q   <= 4'd0;
          cnt_q    <= HALF_PRELOAD;
        end
      end else if (cnt_q == CNT_MAX) begin
        cnt_q  <= '0;
        bits_q <= bits_q + 4'd1;
        if (bits_q == 4'd0) begin
          if (sync_q[1]) active_q <= 1'b0;
        end else if (bits_q == 4'd9) begin
          active_q <= 1'b0;
          ready_q  <= 1'b1;
          ferr_q   <= !sync_q[1];
          rdata_q  <= shift_q;
        end else begin
          shift_q <= {sync_q[1], shift_q[7:1]};
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a start request while idle launches one ten-bit frame.
module uart_tx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CLKS - 1);

  logic [9:0]    shift_q;
  logic [3:0]    bits_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  assign txd     = shift_q[0];
  assign tx_busy = busy_q;

  // Shift out {stop, data, start} LSB first, refilling with idle-high ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift_q <= '1;
      bits_q  <= 4'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (!busy_q) begin
      if (tx_start) begin
        shift_q <= {1'b1, tx_data, 1'b0};
        bits_q  <= 4'd0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else if (cnt_q == CNT_MAX) begin
      cnt_q   <= '0;
      shift_q <= {1'b1, shift_q[9:1]};
      bits_q  <= bits_q + 4'd1;
      if (bits_q == 4'd9) busy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_loopback_fifo.sv
// Buffered UART echo: received bytes are queued in a FIFO and drained back
// out through the transmitter, with pause, frame-error filtering and
// saturating drop counters.
module uart_loopback_fifo
  import uart_defs::*;
#(
  parameter int CLK_PER_HALF_BIT = DEFAULT_CLK_PER_HALF_BIT,
  parameter int FIFO_AW          = 4,
  parameter bit DROP_FERR        = 1'b1,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  output logic             txd,
  input  logic             tx_en,
  output logic [FIFO_AW:0] fifo_count,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] ferr_cnt,
  output logic             busy
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] ferr_cnt_q, ferr_cnt_d;
  logic             rstn;
  logic             rx_ready, ferr;
  logic [7:0]       rdata, tx_data;
  logic             tx_start, tx_busy;
  logic             push, pop, full, empty;

  assign rstn     = ~rst;
  assign push     = rx_ready && !(ferr && DROP_FERR);
  assign ovf_cnt  = ovf_cnt_q;
  assign ferr_cnt = ferr_cnt_q;
  assign busy     = !empty || (state_q != IDLE);

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rdata    (rdata),
    .rx_ready (rx_ready),
    .ferr     (ferr)
  );

  // The FIFO read register doubles as the transmit data register: it only
  // changes on a pop, which happens solely in IDLE, so it is stable per frame.
  byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rdata),
    .pop   (pop),
    .dout  (tx_data),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .txd      (txd),
    .tx_busy  (tx_busy)
  );

  // TX FSM next state: pop in IDLE, one-cycle start strobe, then track tx_busy.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_en && !empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT_HI;
      end
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drop counters: frame errors always counted, overflow only when no pop frees a slot.
  always_comb begin
    ferr_cnt_d = ferr_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (rx_ready && ferr) ferr_cnt_d = CNT_W'(sat_inc(32'(ferr_cnt_q), CNT_MAX));
    if (push && full && !pop) ovf_cnt_d = CNT_W'(sat_inc(32'(ovf_cnt_q), CNT_MAX));
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ovf_cnt_q  <= '0;
      ferr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ovf_cnt_q  <= ovf_cnt_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

endmodule

// File: doc/uart_loopback_fifo.md
Name: uart_loopback_fifo

Overview:
- Buffered, parametrised UART echo block; successor to the single-byte loopback.
- Received bytes go into a synchronous FIFO. A transmit FSM drains it through uart_tx, so back-to-back frames are not lost while the transmitter is busy.
- Adds a transmit pause input, optional frame-error filtering, saturating drop counters and FIFO occupancy status.
- Used as a board-bring-up / link-test top and as the template for the CPU's buffered serial port.

Parameters:
- CLK_PER_HALF_BIT, 5208: clk cycles per half UART bit; passed unchanged to uart_tx and uart_rx.
- FIFO_AW, 4: FIFO address width. Depth = 2**FIFO_AW entries of 8 bits.
- DROP_FERR, 1: when 1, bytes received with ferr=1 are discarded; when 0 they are enqueued normally.
- CNT_W, 8: width of the saturating drop counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rxd  in  1  UART receive line (idle high)
- txd  out  1  UART transmit line (idle high)
- tx_en  in  1  1 = transmitter may start new frames; 0 = pause (bytes accumulate in the FIFO)
- fifo_count  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW
- ovf_cnt  out  CNT_W  bytes dropped because the FIFO was full; saturating
- ferr_cnt  out  CNT_W  frames received with ferr=1; saturating; counted regardless of DROP_FERR
- busy  out  1  1 when the FIFO is non-empty or the TX FSM is not in IDLE

Behaviour:
- Clock and reset:
  - All state updates on posedge clk.
  - rst=1 sampled at an edge clears: FIFO pointers, fifo_count=0, ovf_cnt=0, ferr_cnt=0, FSM=IDLE, tx_start=0, data register=0.
  - busy=0 after reset.
  - uart_tx and uart_rx instances receive rstn = ~rst, so txd returns to idle high.
- Receive side (on each rx_ready pulse from uart_rx, one cycle wide):
  - If ferr=1: ferr_cnt increments unless it is at all-ones. If DROP_FERR=1 the byte is discarded.
  - Otherwise (or ferr=1 with DROP_FERR=0): push rdata.
  - If the FIFO is full and no pop occurs in the same cycle: the byte is dropped and ovf_cnt increments, saturating.
  - Push and pop in the same cycle both take effect. When full, this means the push is accepted and fifo_count is unchanged.
- FIFO:
  - Write at wr_ptr, read at rd_ptr, both FIFO_AW bits wide and wrapping modulo depth.
  - fifo_count is updated +1 / -1 / 0 per cycle.
  - empty = (fifo_count==0); full = (fifo_count==2**FIFO_AW).
  - Read data is registered on pop.
- TX FSM, 4 states:
  - IDLE: if tx_en && !empty && !tx_busy, pop the FIFO head into the data register and go to START.
  - START: drive tx_start=1 for exactly this one cycle, then go to WAIT_HI.
  - WAIT_HI: stay until tx_busy=1, then go to WAIT_LO.
  - WAIT_LO: stay until tx_busy=0, then go to IDLE.
  - The data register is held stable from START until the return to IDLE.
  - tx_en=0 only blocks the IDLE->START transition; a frame already in progress completes.
- Latency:
  - With an empty FIFO, idle transmitter and tx_en=1: rx_ready in cycle t, FIFO write at edge t+1, pop at edge t+2, tx_start=1 during cycle t+2.
  - The start bit appears on txd per uart_tx timing.
- Throughput:
  - Consecutive frames are separated by 3 clk cycles beyond the uart_tx busy period (WAIT_LO->IDLE->START->tx_start).
- Reset mid-frame:
  - The frame is aborted and txd goes high as soon as uart_tx reset completes.
  - The FIFO contents are lost; no partial byte is replayed.

Decomposition:
- Shared package/include uart_defs:
  - TX FSM state encodings (IDLE=2'd0, START=2'd1, WAIT_HI=2'd2, WAIT_LO=2'd3).
  - Default CLK_PER_HALF_BIT=5208.
  - The saturating-increment helper.
- One sub-module, byte_fifo #(FIFO_AW):
  - Ports: clk, rst, push, din[7:0], pop, dout[7:0], count, full, empty.
  - The top contains only the FSM, counters, and the uart_tx/uart_rx instances.

Test Plan (sim with CLK_PER_HALF_BIT=4, FIFO_AW=2):
- Single byte: send 0xA5 on rxd with tx_en=1 -> tx_start exactly 2 cycles after rx_ready, 0xA5 echoed on txd, fifo_count back to 0, busy=0.
- Burst: send 0x01,0x02,0x03 back-to-back -> echoed in order 0x01,0x02,0x03, ovf_cnt=0, fifo_count peaks at ≤2.
- Overflow: tx_en=0, send 6 bytes 0x10..0x15 -> fifo_count=4, ovf_cnt=2. Then tx_en=1 -> echoes 0x10..0x13 only.
- Frame error: send 0x5A with stop bit low, DROP_FERR=1 -> ferr_cnt=1, no tx_start. Repeat with DROP_FERR=0 -> ferr_cnt=1, byte echoed.
- Saturation: CNT_W=2, force 5 overflows -> ovf_cnt holds 3.
- Reset mid-frame: assert rst during WAIT_LO with 2 bytes queued -> next cycle fifo_count=0, FSM=IDLE, txd=1 after uart_tx reset, no further tx_start.
